// File: rtl/vga_pkg.sv
// Shared framebuffer definitions for the VGA blocks.
//   FB_ADDR_W : framebuffer address width, {bank, row[6:0], col[6:0]}
//   FB_DATA_W : pixel width, RRGGBB in [5:0]
//   slot_t    : owner of the single RAM port for the coming cycle
package vga_pkg;
  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 8;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_DISP,
    SLOT_HOST
  } slot_t;
endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle around the framebuffer arbiter.
//   disp_*     : scan-out read request / returned pixel
//   wr_*       : host pixel write, valid/ready handshake
//   ram_*      : single-port synchronous framebuffer RAM
//   fifo_level : host write buffer occupancy
//   disp_miss  : sticky flag, display read could not be issued
// slave modport is the arbiter side, master the surrounding system.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int LVL_W  = 3
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [LVL_W-1:0]  fifo_level;
  logic              disp_miss;

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    output disp_valid, disp_data, wr_ready, ram_en, ram_we, ram_addr,
           ram_wdata, fifo_level, disp_miss
  );

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    input  disp_valid, disp_data, wr_ready, ram_en, ram_we, ram_addr,
           ram_wdata, fifo_level, disp_miss
  );
endinterface

// File: rtl/vga_wr_fifo.sv
// Host write buffer: plain synchronous FIFO, no read-before-write bypass.
//   clk/reset : rising edge, synchronous active-high reset
//   push/din  : enqueue (ignored when full)
//   pop/dout  : dequeue (ignored when empty); dout shows the head
//   full/empty/level : occupancy from registered state
module vga_wr_fifo
  import vga_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = FB_ADDR_W + FB_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  // pointers wrap modulo DEPTH (power of two)
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // storage is not reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: scan-out reads have absolute priority every
// cycle; host writes queue in vga_wr_fifo and drain on free cycles.
//   clk, reset : rising edge, synchronous active-high reset
//   bus        : vga_fb_arbiter_if.slave (display, host, RAM, status)
// Read latency is fixed: request sampled at edge N, RAM enabled in N+1,
// ram_rdata valid in N+2, registered disp_data/disp_valid in N+3.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  vga_fb_arbiter_if.slave bus
);
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int STAGES = 1;

  slot_t             slot;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] disp_data;
  logic [STAGES:0]   vld_pipe;
  logic              disp_miss;

  logic                     f_push, f_pop, f_full, f_empty;
  logic [ADDR_W+DATA_W-1:0] f_dout;
  logic [LVL_W-1:0]         f_level;

  // wr_ready comes from registered occupancy, so a pop at the same edge
  // does not open a slot for the beat offered alongside it
  assign f_push = bus.wr_valid & ~f_full;
  assign f_pop  = ~bus.disp_req & ~f_empty;

  vga_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (f_push),
    .din   ({bus.wr_addr, bus.wr_data}),
    .pop   (f_pop),
    .dout  (f_dout),
    .full  (f_full),
    .empty (f_empty),
    .level (f_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      slot      <= SLOT_IDLE;
      ram_addr  <= '0;
      ram_wdata <= '0;
      disp_data <= '0;
      vld_pipe  <= '0;
      disp_miss <= 1'b0;
    end else begin
      if (bus.disp_req) begin
        slot     <= SLOT_DISP;
        ram_addr <= bus.disp_addr;
      end else if (!f_empty) begin
        slot                  <= SLOT_HOST;
        {ram_addr, ram_wdata} <= f_dout;
      end else begin
        slot <= SLOT_IDLE;  // address/data hold their last values
      end
      // [0]: ram_rdata valid this cycle, [STAGES]: disp_data valid
      vld_pipe <= {vld_pipe[STAGES-1:0], slot == SLOT_DISP};
      if (vld_pipe[0]) disp_data <= bus.ram_rdata;
      // a display request losing the port would be a priority bug
      if (bus.disp_req && f_pop) disp_miss <= 1'b1;
    end
  end

  assign bus.ram_en     = (slot != SLOT_IDLE);
  assign bus.ram_we     = (slot == SLOT_HOST);
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_wdata  = ram_wdata;
  assign bus.disp_valid = vld_pipe[STAGES];
  assign bus.disp_data  = disp_data;
  assign bus.wr_ready   = ~f_full;
  assign bus.fifo_level = f_level;
  assign bus.disp_miss  = disp_miss;
endmodule
